// File: rtl/imem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imem_responder: fetch responder with two-word memory fill and hit buffer |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module imem_responder #(
  parameter int BUF_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] im_req_addr,
  input  logic        im_req_valid,
  output logic [63:0] im_resp_rdata,
  output logic        im_resp_valid,
  output logic [63:0] mem_req_addr,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  input  logic [31:0] mem_resp_rdata,
  input  logic        mem_resp_valid,
  input  logic        flush,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE0 = 3'd1,
    WAIT0  = 3'd2,
    ISSUE1 = 3'd3,
    WAIT1  = 3'd4,
    RESP   = 3'd5
  } state_t;

  localparam logic BUF_ON = (BUF_EN != 0);

  state_t      state_q, state_d;
  logic [60:0] tag_q, tag_d;
  logic [31:0] data_lo_q, data_lo_d;
  logic [60:0] buf_tag_q, buf_tag_d;
  logic [63:0] buf_data_q, buf_data_d;
  logic        buf_valid_q, buf_valid_d;
  logic        flush_seen_q, flush_seen_d;
  logic [63:0] rdata_q, rdata_d;
  logic [63:0] addr_q, addr_d;
  logic        resp_valid_q, resp_valid_d;
  logic        req_valid_q, req_valid_d;
  logic        busy_q, busy_d;
  logic        hit;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^im_req_addr[2:0];

  always_comb begin
    hit          = BUF_ON && buf_valid_q && !flush && (im_req_addr[63:3] == buf_tag_q);
    state_d      = state_q;
    tag_d        = tag_q;
    data_lo_d    = data_lo_q;
    buf_tag_d    = buf_tag_q;
    buf_data_d   = buf_data_q;
    buf_valid_d  = buf_valid_q && !flush;
    flush_seen_d = flush_seen_q || flush;
    rdata_d      = rdata_q;

    case (state_q)
      IDLE: begin
        // A flush coinciding with the request poisons the fill about to start
        flush_seen_d = flush;
        if (im_req_valid) begin
          tag_d = im_req_addr[63:3];
          if (hit) begin
            state_d = RESP;
            rdata_d = buf_data_q;
          end else begin
            state_d = ISSUE0;
          end
        end
      end
      ISSUE0: if (mem_req_ready) state_d = WAIT0;
      WAIT0: begin
        if (mem_resp_valid) begin
          data_lo_d = mem_resp_rdata;
          state_d   = ISSUE1;
        end
      end
      ISSUE1: if (mem_req_ready) state_d = WAIT1;
      WAIT1: begin
        if (mem_resp_valid) begin
          state_d = RESP;
          rdata_d = {mem_resp_rdata, data_lo_q};
          if (BUF_ON && !flush_seen_q && !flush) begin
            buf_valid_d = 1'b1;
            buf_tag_d   = tag_q;
            buf_data_d  = {mem_resp_rdata, data_lo_q};
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state
    req_valid_d = (state_d == ISSUE0) || (state_d == ISSUE1);
    case (state_d)
      ISSUE0:  addr_d = {tag_d, 3'b000};
      ISSUE1:  addr_d = {tag_d, 3'b100};
      default: addr_d = addr_q;
    endcase
    resp_valid_d = (state_d == RESP);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tag_q        <= '0;
      data_lo_q    <= '0;
      buf_tag_q    <= '0;
      buf_data_q   <= '0;
      buf_valid_q  <= 1'b0;
      flush_seen_q <= 1'b0;
      rdata_q      <= '0;
      addr_q       <= '0;
      resp_valid_q <= 1'b0;
      req_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      data_lo_q    <= data_lo_d;
      buf_tag_q    <= buf_tag_d;
      buf_data_q   <= buf_data_d;
      buf_valid_q  <= buf_valid_d;
      flush_seen_q <= flush_seen_d;
      rdata_q      <= rdata_d;
      addr_q       <= addr_d;
      resp_valid_q <= resp_valid_d;
      req_valid_q  <= req_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign im_resp_rdata = rdata_q;
  assign im_resp_valid = resp_valid_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_valid = req_valid_q;
  assign busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_imem_responder: directed self-checking bench for imem_responder       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] im_req_addr = '0;
  logic        im_req_valid = 1'b0;
  logic [63:0] im_resp_rdata;
  logic        im_resp_valid;
  logic [63:0] mem_req_addr;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_resp_rdata = '0;
  logic        mem_resp_valid = 1'b0;
  logic        flush = 1'b0;
  logic        busy;

  int compared = 0;
  int mismatched = 0;

  imem_responder #(.BUF_EN(1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .im_req_addr    (im_req_addr),
    .im_req_valid   (im_req_valid),
    .im_resp_rdata  (im_resp_rdata),
    .im_resp_valid  (im_resp_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_rdata (mem_resp_rdata),
    .mem_resp_valid (mem_resp_valid),
    .flush          (flush),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered and left on a falling edge; inputs change only on falling edges.
  task automatic miss_txn(input string nm, input logic [63:0] a,
                          input logic [63:0] lo_exp, input logic [63:0] hi_exp,
                          input logic [31:0] w0, input logic [31:0] w1,
                          input int stall, input bit poke,
                          input bit fl_wait1, input bit fl_req);
    im_req_addr  = a;
    im_req_valid = 1'b1;
    flush        = fl_req;
    @(negedge clk);
    im_req_valid = 1'b0;
    flush        = 1'b0;
    for (int i = 0; i < stall; i++) begin
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_rdata = 32'hDEADBEEF;
      chk({nm, "_stall_valid"}, mem_req_valid, 1'b1);
      chk({nm, "_stall_addr"}, mem_req_addr, lo_exp);
      chk({nm, "_stall_busy"}, busy, 1'b1);
      if (poke && i == 1) im_req_valid = 1'b1;
      @(negedge clk);
      im_req_valid = 1'b0;
    end
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    chk({nm, "_issue0_valid"}, mem_req_valid, 1'b1);
    chk({nm, "_issue0_addr"}, mem_req_addr, lo_exp);
    chk({nm, "_issue0_busy"}, busy, 1'b1);
    @(negedge clk);
    chk({nm, "_wait0_valid"}, mem_req_valid, 1'b0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = w0;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk({nm, "_issue1_valid"}, mem_req_valid, 1'b1);
    chk({nm, "_issue1_addr"}, mem_req_addr, hi_exp);
    chk({nm, "_issue1_noresp"}, im_resp_valid, 1'b0);
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = w1;
    flush          = fl_wait1;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    flush          = 1'b0;
    chk({nm, "_resp_valid"}, im_resp_valid, 1'b1);
    chk({nm, "_resp_rdata"}, im_resp_rdata, {w1, w0});
    @(negedge clk);
    chk({nm, "_done_valid"}, im_resp_valid, 1'b0);
    chk({nm, "_done_busy"}, busy, 1'b0);
    chk({nm, "_hold_rdata"}, im_resp_rdata, {w1, w0});
    @(negedge clk);
    chk({nm, "_no_extra_resp"}, im_resp_valid, 1'b0);
  endtask

  task automatic hit_txn(input string nm, input logic [63:0] a, input logic [63:0] exp);
    im_req_addr  = a;
    im_req_valid = 1'b1;
    @(negedge clk);
    im_req_valid = 1'b0;
    chk({nm, "_valid"}, im_resp_valid, 1'b1);
    chk({nm, "_rdata"}, im_resp_rdata, exp);
    chk({nm, "_no_memreq"}, mem_req_valid, 1'b0);
    @(negedge clk);
    chk({nm, "_done_valid"}, im_resp_valid, 1'b0);
    chk({nm, "_done_busy"}, busy, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", im_resp_valid, 1'b0);
    chk("rst_resp_rdata", im_resp_rdata, 64'h0);
    chk("rst_mem_valid", mem_req_valid, 1'b0);
    chk("rst_mem_addr", mem_req_addr, 64'h0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    miss_txn("first_miss", 64'h10000000, 64'h10000000, 64'h10000004,
             32'h00000013, 32'h00100093, 0, 1'b0, 1'b0, 1'b0);
    hit_txn("hit_upper", 64'h10000004, 64'h0010009300000013);

    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    miss_txn("post_flush", 64'h10000000, 64'h10000000, 64'h10000004,
             32'hAAAA0001, 32'hBBBB0002, 0, 1'b0, 1'b0, 1'b0);
    hit_txn("hit_refill", 64'h10000000, 64'hBBBB0002AAAA0001);

    // Unaligned low bits, backpressure, stray response and dropped request
    miss_txn("stall", 64'h2000001F, 64'h20000018, 64'h2000001C,
             32'h11111111, 32'h22222222, 3, 1'b1, 1'b0, 1'b0);
    hit_txn("hit_stall", 64'h20000018, 64'h2222222211111111);

    miss_txn("flush_with_req", 64'h20000018, 64'h20000018, 64'h2000001C,
             32'h33333333, 32'h44444444, 0, 1'b0, 1'b0, 1'b1);

    miss_txn("flush_wait1", 64'h30000000, 64'h30000000, 64'h30000004,
             32'h55555555, 32'h66666666, 0, 1'b0, 1'b1, 1'b0);
    miss_txn("after_flush_wait1", 64'h30000000, 64'h30000000, 64'h30000004,
             32'h77777777, 32'h88888888, 0, 1'b0, 1'b0, 1'b0);

    miss_txn("prefill", 64'h50000000, 64'h50000000, 64'h50000004,
             32'hCAFE0001, 32'hCAFE0002, 0, 1'b0, 1'b0, 1'b0);

    // Reset while waiting for the first word, then a late memory response
    im_req_addr  = 64'h60000000;
    im_req_valid = 1'b1;
    @(negedge clk);
    im_req_valid = 1'b0;
    chk("abort_issue0_valid", mem_req_valid, 1'b1);
    @(negedge clk);
    chk("abort_wait0_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_async_busy", busy, 1'b0);
    chk("abort_async_memvalid", mem_req_valid, 1'b0);
    chk("abort_async_memaddr", mem_req_addr, 64'h0);
    @(negedge clk);
    rst_n          = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h00000099;
    @(negedge clk);
    chk("abort_late_resp_valid", im_resp_valid, 1'b0);
    chk("abort_late_busy", busy, 1'b0);
    mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("abort_idle_resp_valid", im_resp_valid, 1'b0);
    chk("abort_idle_busy", busy, 1'b0);
    chk("abort_idle_rdata", im_resp_rdata, 64'h0);

    miss_txn("first_after_rst", 64'h50000000, 64'h50000000, 64'h50000004,
             32'h0BAD0001, 32'h0BAD0002, 0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter: BUF_EN, default 1, meaning enable the one-entry doubleword hit buffer (0 = every request is a miss).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 im_req_addr  input  64  fetch byte address; bits [2:0] ignored.
REQ-005 im_req_valid  input  1  single-cycle request pulse from fetch pipeline.
REQ-006 im_resp_rdata  output  64  doubleword at {addr[63:3],3'b000}; [31:0] = lower word.
REQ-007 im_resp_valid  output  1  one-cycle pulse qualifying im_resp_rdata.
REQ-008 mem_req_addr  output  64  word address to backing memory, bits [1:0] = 0.
REQ-009 mem_req_valid  output  1  backing-memory request valid.
REQ-010 mem_req_ready  input  1  backing-memory accepts when valid && ready.
REQ-011 mem_resp_rdata  input  32  returned word.
REQ-012 mem_resp_valid  input  1  qualifies mem_resp_rdata.
REQ-013 flush  input  1  invalidate hit buffer (fence.i).
REQ-014 busy  output  1  high whenever state != IDLE.

Function
REQ-015 State machine SHALL have states IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
REQ-016 IDLE: im_req_valid sampled only here; address latched as tag = im_req_addr[63:3].
REQ-017 Hit = BUF_EN && buf_valid && !flush && im_req_addr[63:3] == buf_tag; hit SHALL go to RESP, driving buffer data.
REQ-018 Miss in IDLE SHALL go to ISSUE0.
REQ-019 ISSUE0: mem_req_valid=1, mem_req_addr={tag,3'b000}; on mem_req_ready go to WAIT0, else hold with address/valid stable.
REQ-020 WAIT0: on mem_resp_valid capture word into data[31:0], go to ISSUE1.
REQ-021 ISSUE1: mem_req_valid=1, mem_req_addr={tag,3'b100}; on ready go to WAIT1.
REQ-022 WAIT1: on mem_resp_valid capture data[63:32], go to RESP.
REQ-023 RESP: im_resp_valid=1 for exactly one cycle, im_resp_rdata=assembled/buffered doubleword; next state IDLE.
REQ-024 im_resp_rdata SHALL hold its last value outside RESP.
REQ-025 Latency: hit, im_resp_valid in cycle after request; miss with ready=1 and resp one cycle after accept, im_resp_valid 5 cycles after request.
REQ-026 mem_resp_valid outside WAIT0/WAIT1 SHALL be ignored.
REQ-027 im_req_valid when not IDLE SHALL be ignored (dropped, no response).
REQ-028 On miss completion (WAIT1->RESP) with BUF_EN, buffer SHALL load tag/data and set buf_valid, unless flush was seen at any cycle since leaving IDLE, in which case buf_valid remains 0.
REQ-029 flush SHALL clear buf_valid at the next edge in any state; flush and request in same IDLE cycle SHALL be treated as a miss.
REQ-030 Address arithmetic: tag+4 offset via bit 2 only; no carry into bit 3.

Reset
REQ-031 rst_n low SHALL asynchronously force state=IDLE, buf_valid=0, buf_tag=0, im_resp_rdata=0, im_resp_valid=0, mem_req_valid=0, mem_req_addr=0, busy=0.
REQ-032 Reset mid-miss SHALL abandon the transaction; late mem_resp_valid after release SHALL be ignored; no im_resp_valid generated for the abandoned request.
REQ-033 First request after reset SHALL always miss.

Verification
REQ-034 Reset release, req addr 0x10000000, ready=1, mem returns 0x00000013 then 0x00100093 -> mem_req_addr 0x10000000 then 0x10000004; im_resp_rdata 0x0010009300000013, valid 5 cycles after request.
REQ-035 Then req 0x10000004 -> hit: im_resp_valid next cycle, same rdata, mem_req_valid stays 0.
REQ-036 flush pulse, then req 0x10000000 -> miss, two mem requests issued.
REQ-037 Miss with mem_req_ready held 0 for 3 cycles in ISSUE0 -> mem_req_valid/addr stable, busy=1, im_req_valid pulse during busy produces no response.
REQ-038 flush asserted during WAIT1 -> response still delivered, subsequent same-address request misses.
REQ-039 rst_n low during WAIT0, mem_resp_valid arrives after release -> no im_resp_valid, state IDLE, busy=0.
